// File: rtl/hs_arbiter.sv
// Round-robin arbiter feeding one requester at a time into a pulse/finish handshake.
// Optional ack-wait watchdog built only when HS_ARB_TIMEOUT_EN is defined.
module hs_arbiter #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_REQ_NUM    = 4,
  parameter int C_TIMEOUT    = 1023
) (
  input  logic                              CLK_I,
  input  logic                              RST_I,
  input  logic [C_REQ_NUM-1:0]              REQ_I,
  input  logic [C_REQ_NUM*C_DATA_WIDTH-1:0] REQ_DATA_I,
  output logic [C_REQ_NUM-1:0]              DONE_O,
  output logic                              BUSY_O,
  output logic [C_DATA_WIDTH+2:0]           HS_DATA_O,
  output logic                              HS_SYNC_PULSE_O,
  input  logic                              HS_SYNC_FINISH_I,
  output logic                              TIMEOUT_O
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_REL
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              ptr_q, ptr_d;
  logic [2:0]              gnt_q, gnt_d;
  logic [C_DATA_WIDTH+2:0] data_q, data_d;
  logic [2:0]              win;
  logic [2:0]              ptr_nxt;
  logic                    release_w;

  // Round-robin search: first set request at or after ptr, wrapping
  always_comb begin
    logic found;
    found = 1'b0;
    win   = ptr_q;
    for (int k = 0; k < C_REQ_NUM; k++) begin
      if (!found && REQ_I[(int'(ptr_q) + k) % C_REQ_NUM]) begin
        found = 1'b1;
        win   = 3'((int'(ptr_q) + k) % C_REQ_NUM);
      end
    end
  end

  assign ptr_nxt = (gnt_q == 3'(C_REQ_NUM - 1)) ? 3'd0 : gnt_q + 3'd1;
  assign release_w = (state_q == WAIT_REL) && !HS_SYNC_FINISH_I;

  // Next-state, grant capture and pointer advance
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (!HS_SYNC_FINISH_I && (|REQ_I)) begin
          state_d = SEND;
          gnt_d   = win;
          data_d  = {win, REQ_DATA_I[int'(win)*C_DATA_WIDTH +: C_DATA_WIDTH]};
        end
      end
      SEND: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (HS_SYNC_FINISH_I) state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!HS_SYNC_FINISH_I) begin
          state_d = IDLE;
          ptr_d   = ptr_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, grant and payload registers
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
    end
  end

  // Completion pulse on the release cycle, only for the granted requester
  always_comb begin
    DONE_O = '0;
    for (int i = 0; i < C_REQ_NUM; i++) begin
      DONE_O[i] = release_w && (gnt_q == 3'(i));
    end
  end

  assign BUSY_O          = (state_q != IDLE);
  assign HS_SYNC_PULSE_O = (state_q == SEND);
  assign HS_DATA_O       = data_q;

`ifdef HS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(C_TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;

  // Ack-wait counter cleared on WAIT_ACK entry; sticky flag at the limit
  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q;
    if (state_q == SEND) begin
      cnt_d = '0;
    end else if (state_q == WAIT_ACK && cnt_q != CW'(C_TIMEOUT)) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (state_q == WAIT_ACK && cnt_d == CW'(C_TIMEOUT)) to_d = 1'b1;
  end

  // Watchdog registers
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign TIMEOUT_O = to_q;
`else
  logic unused_timeout;
  assign unused_timeout = (C_TIMEOUT != 0);
  assign TIMEOUT_O      = 1'b0;
`endif

endmodule

// File: tb/tb_hs_arbiter.sv
// Scoreboard bench for hs_arbiter: model predicts grants, monitor checks outputs.
// Optional watchdog scenario runs when HS_ARB_TIMEOUT_EN is defined.
module tb_hs_arbiter;
  localparam int DW = 32;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            fin = 1'b0;
  logic [N-1:0]    req_v = '0;
  logic [DW-1:0]   pay [N];
  logic [N-1:0]    done;
  logic            busy;
  logic [DW+2:0]   hs_data;
  logic            pulse;
  logic            tmo;
  logic [N*DW-1:0] req_data;

  int errs = 0;
  int checks = 0;
  int ptr_m = 0;
  bit prev_pulse = 1'b0;

  logic [DW+2:0] exp_data_q[$];
  logic [N-1:0]  exp_done_q[$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pay[i];
  end

  hs_arbiter #(
    .C_DATA_WIDTH(DW),
    .C_REQ_NUM(N),
    .C_TIMEOUT(15)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .REQ_I(req_v),
    .REQ_DATA_I(req_data),
    .DONE_O(done),
    .BUSY_O(busy),
    .HS_DATA_O(hs_data),
    .HS_SYNC_PULSE_O(pulse),
    .HS_SYNC_FINISH_I(fin),
    .TIMEOUT_O(tmo)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    errs++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  // Monitor: compares every launch and completion against the scoreboard
  always @(negedge clk) begin
    if (pulse) begin
      chk("pulse_single", 64'(prev_pulse), 64'd0);
      if (exp_data_q.size() == 0) bad("unexpected_pulse");
      else chk("hs_data", 64'(hs_data), 64'(exp_data_q.pop_front()));
    end
    if (done != '0) begin
      chk("done_onehot", 64'($onehot(done)), 64'd1);
      if (exp_done_q.size() == 0) bad("unexpected_done");
      else chk("done_vec", 64'(done), 64'(exp_done_q.pop_front()));
`ifndef HS_ARB_TIMEOUT_EN
      chk("timeout_off", 64'(tmo), 64'd0);
`endif
    end
    prev_pulse = pulse;
  end

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (req_v[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return 0;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    exp_data_q.delete();
    exp_done_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(hs_data), 64'd0);
    chk("rst_pulse", 64'(pulse), 64'd0);
    chk("rst_timeout", 64'(tmo), 64'd0);
    rst = 1'b0;
    ptr_m = 0;
  endtask

  task automatic start_xfer(output int w);
    w = pick();
    exp_data_q.push_back({3'(w), pay[w]});
    exp_done_q.push_back(N'(1 << w));
  endtask

  task automatic wait_pulse(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pulse) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bad("pulse_timeout");
  endtask

  task automatic finish_xfer(input int w, input int fd, input int rd,
                             input bit drop, input bit chg, input bit extra,
                             input bit keep);
    bit got;
    if (extra) req_v = req_v | N'($urandom);
    if (chg) pay[w] = $urandom;
    if (drop) req_v[w] = 1'b0;
    repeat (fd) @(posedge clk);
    #1 fin = 1'b1;
    repeat (rd) @(posedge clk);
    #1 fin = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done != '0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) bad("done_timeout");
    if (!keep) req_v[w] = 1'b0;
    ptr_m = (w + 1) % N;
  endtask

  task automatic xfer(input int fd, input int rd, input bit drop,
                      input bit chg, input bit extra, input bit keep);
    int w;
    bit ok;
    start_xfer(w);
    wait_pulse(ok);
    if (ok) finish_xfer(w, fd, rd, drop, chg, extra, keep);
  endtask

  initial begin
    int w;
    bit ok;
    for (int i = 0; i < N; i++) pay[i] = 32'h1000_0000 + i;
    do_reset();

    // Round-robin with every requester asserted
    req_v = 4'b1111;
    for (int i = 0; i < 4; i++) xfer(2, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single request with long finish delays
    req_v = 4'b0010;
    pay[1] = 32'hA5A5_A5A5;
    xfer(6, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_after", 64'(busy), 64'd0);

    // Fairness with two requests held throughout
    do_reset();
    req_v = 4'b0101;
    for (int i = 0; i < 4; i++) xfer(1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    req_v = '0;

    // Reset while waiting for the ack
    req_v = 4'b1001;
    start_xfer(w);
    wait_pulse(ok);
    repeat (2) @(posedge clk);
    do_reset();
    xfer(1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    xfer(1, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stale finish blocks launch until it drops
    fin = 1'b1;
    do_reset();
    req_v = 4'b0001;
    start_xfer(w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stale_block", 64'(pulse), 64'd0);
    end
    @(posedge clk);
    #1 fin = 1'b0;
    @(negedge clk);
    chk("stale_wait", 64'(pulse), 64'd0);
    @(negedge clk);
    chk("stale_launch", 64'(pulse), 64'd1);
    finish_xfer(w, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      if (req_v == '0) req_v = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) pay[i] = $urandom;
      xfer($urandom_range(1, 4), $urandom_range(1, 4),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, 1'b0);
    end
    req_v = '0;

`ifdef HS_ARB_TIMEOUT_EN
    // Watchdog trips after 15 ack-wait cycles and stays set
    do_reset();
    req_v = 4'b0001;
    start_xfer(w);
    wait_pulse(ok);
    if (ok) begin
      repeat (15) @(negedge clk);
      chk("timeout_early", 64'(tmo), 64'd0);
      @(negedge clk);
      chk("timeout_set", 64'(tmo), 64'd1);
      finish_xfer(w, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("timeout_sticky", 64'(tmo), 64'd1);
    end
`endif

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(exp_data_q.size() + exp_done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/hs_arbiter.md
HS_ARBITER -- requirements
Module: hs_arbiter

Interface
REQ-001 The block SHALL have parameter C_DATA_WIDTH, default 32, giving the payload width per requester.
REQ-002 The block SHALL have parameter C_REQ_NUM, default 4, range 2-8, giving the requester count.
REQ-003 The block SHALL have parameter C_TIMEOUT, default 1023, giving the ack-wait limit in cycles; it is used only under HS_ARB_TIMEOUT_EN.
REQ-004 The block SHALL have port CLK_I, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RST_I, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port REQ_I, input, C_REQ_NUM bits: per-requester level request, held until the matching DONE_O pulse.
REQ-007 The block SHALL have port REQ_DATA_I, input, C_REQ_NUM*C_DATA_WIDTH bits: requester i payload in bits [i*C_DATA_WIDTH +: C_DATA_WIDTH].
REQ-008 The block SHALL have port DONE_O, output, C_REQ_NUM bits: one-cycle pulse per requester on completed transfer.
REQ-009 The block SHALL have port BUSY_O, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-010 The block SHALL have port HS_DATA_O, output, C_DATA_WIDTH+3 bits: {3-bit requester ID, payload}, driving the handshake SRC_DATA_I.
REQ-011 The block SHALL have port HS_SYNC_PULSE_O, output, 1 bit: launch pulse to the handshake SRC_SYNC_PULSE_I.
REQ-012 The block SHALL have port HS_SYNC_FINISH_I, input, 1 bit: the handshake SRC_SYNC_FINISH_O.
REQ-013 The block SHALL have port TIMEOUT_O, output, 1 bit: sticky timeout flag.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, WAIT_ACK and WAIT_REL.
REQ-015 IDLE SHALL leave only when HS_SYNC_FINISH_I=0 and at least one REQ_I bit is high; a stale high finish blocks launch.
REQ-016 Arbitration SHALL be round-robin: search starts at index ptr and wraps modulo C_REQ_NUM; the first set bit wins.
REQ-017 The grant SHALL be registered on the IDLE->SEND transition, and HS_DATA_O SHALL be loaded with {winner ID, winner payload} on the same edge.
REQ-018 HS_DATA_O SHALL hold that value until the next grant.
REQ-019 In SEND, HS_SYNC_PULSE_O SHALL be high for exactly one cycle, which is the cycle after REQ_I is sampled; the FSM then moves to WAIT_ACK.
REQ-020 HS_SYNC_FINISH_I SHALL be ignored in SEND.
REQ-021 WAIT_ACK SHALL move to WAIT_REL on the first cycle HS_SYNC_FINISH_I=1.
REQ-022 WAIT_REL SHALL wait for HS_SYNC_FINISH_I=0, then pulse DONE_O[winner] for one cycle, set ptr=winner+1 (wrapping), and return to IDLE.
REQ-023 Winner payload changes after the grant SHALL NOT affect HS_DATA_O.
REQ-024 If REQ_I[winner] drops mid-transfer, the transfer SHALL still complete and DONE_O SHALL still pulse.
REQ-025 REQ_I changes outside IDLE SHALL NOT affect the grant.
REQ-026 At most one DONE_O bit SHALL be high in any cycle.
REQ-027 A new grant SHALL be possible no earlier than the cycle after DONE_O.

Reset
REQ-028 While RST_I=1, at the next edge: FSM=IDLE, ptr=0, HS_DATA_O=0, HS_SYNC_PULSE_O=0, DONE_O=0, BUSY_O=0, TIMEOUT_O=0, timeout counter=0.
REQ-029 Reset mid-transfer SHALL abandon the transfer with no DONE_O pulse.
REQ-030 The integrator SHALL reset the attached handshake wrapper with the same RST_I.

Configuration
REQ-031 With macro HS_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT_ACK and increment each WAIT_ACK cycle.
REQ-032 With HS_ARB_TIMEOUT_EN defined, reaching C_TIMEOUT SHALL set TIMEOUT_O=1 until reset; the FSM keeps waiting and behaviour is otherwise unchanged.
REQ-033 Without HS_ARB_TIMEOUT_EN, no counter SHALL be built and TIMEOUT_O SHALL be constant 0.

Verification
REQ-034 Single request: C_REQ_NUM=4, REQ_I=0010, payload 0xA5A5A5A5, finish high 6 cycles after the pulse then low 5 cycles later -> one HS_SYNC_PULSE_O, HS_DATA_O=0x1_A5A5A5A5, DONE_O=0010 once, BUSY_O low after.
REQ-035 Round-robin: REQ_I=1111 held, each request dropped after its own DONE -> grant order 0,1,2,3, exactly one DONE each, no overlap.
REQ-036 Fairness: REQ_I=0101 held continuously -> grants alternate 0,2,0,2 over 4 transfers.
REQ-037 Stale finish: HS_SYNC_FINISH_I=1 after reset with REQ_I=0001 -> no pulse until finish=0, then pulse after 1 cycle.
REQ-038 Reset mid-transfer: RST_I pulse in WAIT_ACK -> all outputs 0, no DONE_O, next grant starts at index 0.
REQ-039 Timeout: HS_ARB_TIMEOUT_EN defined, C_TIMEOUT=15, finish never rises -> TIMEOUT_O=1 after 15 WAIT_ACK cycles and stays; a later finish still completes with DONE_O.
